mult_pipe_cell: RTL

MULT_PIPE_CELL -- requirements
Module: mult_pipe_cell

---
 rtl/mult_pipe_pkg.sv | 28 ++
 rtl/mult_pipe_subprod.sv | 14 +
 rtl/mult_pipe_cell.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mult_pipe_pkg.sv
// mult_pipe_pkg: shared types for the iterative multiplier cell.
//   mode_e  : operation select (low half MUL, or high half with signedness).
//   state_e : control FSM state, also exposed on the debug port.
//   src1_signed / src2_signed : signedness of each operand for a mode.
package mult_pipe_pkg;

   typedef enum logic [1:0] {
      MODE_MUL    = 2'b00,  // low half, operands treated unsigned
      MODE_MULXSS = 2'b01,  // high half, signed x signed
      MODE_MULXUU = 2'b10,  // high half, unsigned x unsigned
      MODE_MULXSU = 2'b11   // high half, signed x unsigned
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   function automatic logic src1_signed(input mode_e m);
      return (m == MODE_MULXSS) || (m == MODE_MULXSU);
   endfunction

   function automatic logic src2_signed(input mode_e m);
      return (m == MODE_MULXSS);
   endfunction

endpackage

// File: rtl/mult_pipe_subprod.sv
// mult_pipe_subprod: combinational unsigned SUB_WIDTH x SUB_WIDTH multiplier.
//   a_i, b_i : unsigned sub-operands
//   p_o      : full 2*SUB_WIDTH-bit product
module mult_pipe_subprod #(
   parameter int SUB_WIDTH = 16
) (
   input  logic [SUB_WIDTH-1:0]   a_i,
   input  logic [SUB_WIDTH-1:0]   b_i,
   output logic [2*SUB_WIDTH-1:0] p_o
);

   assign p_o = (2*SUB_WIDTH)'(a_i) * (2*SUB_WIDTH)'(b_i);

endmodule

// File: rtl/mult_pipe_cell.sv
// mult_pipe_cell: iterative WIDTH x WIDTH multiplier built around one
// SUB_WIDTH x SUB_WIDTH sub-multiplier.
//
// Operation: operands are converted to magnitudes on acceptance, then one
// partial product per cycle is shifted into a 2*WIDTH accumulator. A final
// CALC cycle applies the sign and selects the result half, so the result
// appears N+1 cycles after acceptance, N = (WIDTH/SUB_WIDTH)^2.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Input side: in_valid/in_ready. Output side: out_valid/out_ready;
// result holds steady while out_valid is high and out_ready is low. In DONE,
// out_ready releases the result and in the same edge new operands may be
// accepted (in_ready follows out_ready there).
//
// Ports:
//   clk, reset         : clock, async active-high reset
//   in_valid, in_ready : operand handshake
//   src1, src2, mode   : operands and operation (see mode_e)
//   out_valid, out_ready, result : result handshake and data
//   dbg_state_o        : current FSM state (state_e encoding)
module mult_pipe_cell
   import mult_pipe_pkg::*;
#(
   parameter int WIDTH     = 32,  // 16, 32 or 64
   parameter int SUB_WIDTH = 16   // WIDTH must be a multiple of this
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [1:0]       dbg_state_o
);

   localparam int K  = WIDTH / SUB_WIDTH;  // sub-words per operand
   localparam int N  = K * K;              // partial products per operation
   localparam int CW = $clog2(N + 1);      // counter must reach N

   state_e                 state_q;
   logic [WIDTH-1:0]       a_q, b_q;       // operand magnitudes
   logic                   neg_q;          // product sign
   mode_e                  mode_q;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [CW-1:0]          cnt_q;
   logic [WIDTH-1:0]       result_q, result_d;

   logic                   accept;
   mode_e                  mode_in;
   logic                   neg1, neg2;
   logic [WIDTH-1:0]       mag1, mag2;
   logic [31:0]            idx_i, idx_j;
   logic [SUB_WIDTH-1:0]   sub_a, sub_b;
   logic [2*SUB_WIDTH-1:0] sub_p;
   logic [2*WIDTH-1:0]     prod_signed;

   assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept      = in_valid && in_ready;
   assign out_valid   = (state_q == ST_DONE);
   assign result      = result_q;
   assign dbg_state_o = state_q;

   // Magnitudes on acceptance. Negating the most-negative value gives back
   // the same bit pattern, which read as unsigned is exactly its magnitude.
   assign mode_in = mode_e'(mode);
   assign neg1    = src1_signed(mode_in) && src1[WIDTH-1];
   assign neg2    = src2_signed(mode_in) && src2[WIDTH-1];
   assign mag1    = neg1 ? -src1 : src1;
   assign mag2    = neg2 ? -src2 : src2;

   // Counter walks (i, j) row-major: i selects the a sub-word, j the b sub-word.
   always_comb begin
      idx_i = 32'(cnt_q) / 32'(K);
      idx_j = 32'(cnt_q) % 32'(K);
      sub_a = SUB_WIDTH'(a_q >> (idx_i * 32'(SUB_WIDTH)));
      sub_b = SUB_WIDTH'(b_q >> (idx_j * 32'(SUB_WIDTH)));
   end

   mult_pipe_subprod #(
      .SUB_WIDTH(SUB_WIDTH)
   ) u_subprod (
      .a_i(sub_a),
      .b_i(sub_b),
      .p_o(sub_p)
   );

   always_comb begin
      acc_d       = acc_q + ((2*WIDTH)'(sub_p) << ((idx_i + idx_j) * 32'(SUB_WIDTH)));
      prod_signed = neg_q ? -acc_q : acc_q;
      result_d    = (mode_q == MODE_MUL) ? prod_signed[WIDTH-1:0]
                                         : prod_signed[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         neg_q    <= 1'b0;
         mode_q   <= MODE_MUL;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else if (accept) begin
         // Covers both IDLE and the no-bubble DONE handoff.
         a_q     <= mag1;
         b_q     <= mag2;
         neg_q   <= neg1 ^ neg2;
         mode_q  <= mode_in;
         acc_q   <= '0;
         cnt_q   <= '0;
         state_q <= ST_CALC;
      end else begin
         case (state_q)
            ST_CALC: begin
               if (cnt_q == CW'(N)) begin
                  result_q <= result_d;
                  state_q  <= ST_DONE;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) state_q <= ST_IDLE;
            end
            ST_IDLE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
